// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared FSM state codes, halt opcode and stall/flush cause encoding
package pipe_ctrl_pkg;
  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_MEM_WAIT = 2'd1;
  localparam logic [1:0] ST_DRAIN    = 2'd2;
  localparam logic [1:0] ST_HALTED   = 2'd3;
  localparam logic [31:0] HALT_INSTR = 32'hFFFF_FFFF;
  typedef enum logic [2:0] {
    C_NONE,
    C_MEM,
    C_LOAD_USE,
    C_REDIRECT,
    C_HALT,
    C_DRAIN,
    C_HALTED
  } cause_e;
endpackage

// File: rtl/pipe_perf_counters.sv
// pipe_perf_counters: wrapping cycle/stall/flush/mem-wait event counters, frozen while disabled
module pipe_perf_counters #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             stall,
  input  logic             flush,
  input  logic             mem_wait,
  output logic [CNT_W-1:0] cyc_cnt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] memwait_cnt
);
  // count events every enabled cycle; natural wrap at 2^CNT_W
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_cnt     <= '0;
      stall_cnt   <= '0;
      flush_cnt   <= '0;
      memwait_cnt <= '0;
    end else if (en) begin
      cyc_cnt     <= cyc_cnt + 1'b1;
      stall_cnt   <= stall_cnt + CNT_W'(stall);
      flush_cnt   <= flush_cnt + CNT_W'(flush);
      memwait_cnt <= memwait_cnt + CNT_W'(mem_wait);
    end
  end
endmodule

// File: rtl/pipeline_stall_sequencer.sv
// pipeline_stall_sequencer: per-stage stall/flush control, drain and halt sequencing; PIPE_PERF_CNT_EN adds perf counters
module pipeline_stall_sequencer
  import pipe_ctrl_pkg::*;
#(
  parameter int DRAIN_CYCLES = 4,
  parameter int MEM_TIMEOUT  = 255,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             hz_stall,
  input  logic             br_redirect,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  input  logic             halt_d,
  output logic             stall_f,
  output logic             stall_d,
  output logic             stall_e,
  output logic             stall_m,
  output logic             flush_d,
  output logic             flush_e,
  output logic             flush_w,
  output logic             halted,
  output logic             mem_err,
  output logic [1:0]       state_o
`ifdef PIPE_PERF_CNT_EN
  ,output logic [CNT_W-1:0] cyc_cnt
  ,output logic [CNT_W-1:0] stall_cnt
  ,output logic [CNT_W-1:0] flush_cnt
  ,output logic [CNT_W-1:0] memwait_cnt
`endif
);
  localparam int DW = $clog2(DRAIN_CYCLES) + 1;
  localparam int TW = $clog2(MEM_TIMEOUT + 1) + 1;
  logic [1:0]    state, state_n;
  logic [DW-1:0] dcnt;
  logic [TW-1:0] tcnt;
  logic          mem_wait, freeze, front;
  cause_e        cause;
  // a pending memory access outranks everything except the final halted freeze
  assign mem_wait = (state != ST_HALTED) & !dmem_ready & (dmem_req | (state == ST_MEM_WAIT));
  // pick the single winning cause for this cycle, then next state from it
  always_comb begin
    cause   = state == ST_HALTED ? C_HALTED :
              mem_wait           ? C_MEM :
              state == ST_DRAIN  ? C_DRAIN :
              hz_stall           ? C_LOAD_USE :
              br_redirect        ? C_REDIRECT :
              halt_d             ? C_HALT : C_NONE;
    state_n = cause == C_MEM     ? (state == ST_DRAIN ? ST_DRAIN : ST_MEM_WAIT) :
              cause == C_HALT    ? ST_DRAIN :
              state == ST_DRAIN  ? (dcnt == '0 ? ST_HALTED : ST_DRAIN) :
              state == ST_MEM_WAIT ? ST_RUN : state;
  end
  assign freeze  = (cause == C_MEM) | (cause == C_HALTED);
  assign front   = freeze | (cause == C_LOAD_USE) | (cause == C_HALT) | (cause == C_DRAIN);
  assign stall_f = front;
  assign stall_d = front;
  assign stall_e = freeze;
  assign stall_m = freeze;
  assign flush_w = freeze;
  assign flush_e = (cause == C_LOAD_USE) | (cause == C_HALT) | (cause == C_DRAIN);
  assign flush_d = cause == C_REDIRECT;
  assign halted  = state == ST_HALTED;
  assign state_o = state;
  // state, drain countdown (held during mem wait) and saturating mem-wait timeout
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_RUN;
      dcnt    <= '0;
      tcnt    <= '0;
      mem_err <= 1'b0;
    end else begin
      state   <= state_n;
      dcnt    <= cause == C_HALT ? DW'(DRAIN_CYCLES - 1) :
                 (cause == C_DRAIN && dcnt != '0) ? dcnt - 1'b1 : dcnt;
      tcnt    <= state != ST_MEM_WAIT ? '0 :
                 (!dmem_ready && tcnt != TW'(MEM_TIMEOUT)) ? tcnt + 1'b1 : tcnt;
      mem_err <= mem_err | ((state == ST_MEM_WAIT) & !dmem_ready & (tcnt >= TW'(MEM_TIMEOUT - 1)));
    end
  end
`ifdef PIPE_PERF_CNT_EN
  pipe_perf_counters #(.CNT_W(CNT_W)) u_perf (
    .clk(clk),
    .rst_n(rst_n),
    .en(state != ST_HALTED),
    .stall(stall_f),
    .flush(flush_d | flush_e),
    .mem_wait(mem_wait),
    .cyc_cnt(cyc_cnt),
    .stall_cnt(stall_cnt),
    .flush_cnt(flush_cnt),
    .memwait_cnt(memwait_cnt)
  );
`endif
endmodule

// File: tb/tb_pipeline_stall_sequencer.sv
// tb_pipeline_stall_sequencer: directed checks of stall/flush priority, mem wait, timeout, drain/halt, async reset
module tb_pipeline_stall_sequencer;
  logic clk = 1'b0, rst_n = 1'b0;
  logic hz_stall = 1'b0, br_redirect = 1'b0, dmem_req = 1'b0, dmem_ready = 1'b0, halt_d = 1'b0;
  logic stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w, halted, mem_err;
  logic [1:0] state_o;
  logic [10:0] outs;
  int n = 0, f = 0;
`ifdef PIPE_PERF_CNT_EN
  logic [31:0] cyc_cnt, stall_cnt, flush_cnt, memwait_cnt;
`endif
  // {state, sf, sd, se, sm, fd, fe, fw, halted, mem_err}
  localparam logic [10:0] IDLE  = 11'b00_0000_000_0_0;
  localparam logic [10:0] LU    = 11'b00_1100_010_0_0;
  localparam logic [10:0] BR    = 11'b00_0000_100_0_0;
  localparam logic [10:0] MEMR  = 11'b00_1111_001_0_0;
  localparam logic [10:0] MEMW  = 11'b01_1111_001_0_0;
  localparam logic [10:0] MWOK  = 11'b01_0000_000_0_0;
  localparam logic [10:0] DRN   = 11'b10_1100_010_0_0;
  localparam logic [10:0] DRNM  = 11'b10_1111_001_0_0;
  localparam logic [10:0] HLT   = 11'b11_1111_001_1_0;

  always #5 clk = ~clk;
  assign outs = {state_o, stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w, halted, mem_err};

  pipeline_stall_sequencer #(.DRAIN_CYCLES(4), .MEM_TIMEOUT(4), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .hz_stall(hz_stall), .br_redirect(br_redirect),
    .dmem_req(dmem_req), .dmem_ready(dmem_ready), .halt_d(halt_d),
    .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e), .stall_m(stall_m),
    .flush_d(flush_d), .flush_e(flush_e), .flush_w(flush_w),
    .halted(halted), .mem_err(mem_err), .state_o(state_o)
`ifdef PIPE_PERF_CNT_EN
    , .cyc_cnt(cyc_cnt), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .memwait_cnt(memwait_cnt)
`endif
  );

  task automatic drive(input logic hz, input logic br, input logic rq, input logic rdy, input logic h);
    hz_stall = hz; br_redirect = br; dmem_req = rq; dmem_ready = rdy; halt_d = h;
  endtask

  task automatic test_reset;
    #1;
    n++; if (outs !== IDLE) begin f++; $display("FAIL reset_held: got %b want %b", outs, IDLE); end
    @(negedge clk); rst_n = 1'b1; #1;
    n++; if (outs !== IDLE) begin f++; $display("FAIL reset_release: got %b want %b", outs, IDLE); end
  endtask

  task automatic test_load_use;
    drive(1, 0, 0, 0, 0); #1;
    n++; if (outs !== LU) begin f++; $display("FAIL load_use: got %b want %b", outs, LU); end
    @(negedge clk); drive(0, 0, 0, 0, 0); #1;
    n++; if (outs !== IDLE) begin f++; $display("FAIL load_use_after: got %b want %b", outs, IDLE); end
  endtask

  task automatic test_hz_and_redirect;
    drive(1, 1, 0, 0, 0); #1;
    n++; if (outs !== LU) begin f++; $display("FAIL hz_over_br: got %b want %b", outs, LU); end
    @(negedge clk); drive(0, 1, 0, 0, 0); #1;
    n++; if (outs !== BR) begin f++; $display("FAIL redirect: got %b want %b", outs, BR); end
    @(negedge clk); drive(0, 0, 0, 0, 0); #1;
    n++; if (outs !== IDLE) begin f++; $display("FAIL redirect_after: got %b want %b", outs, IDLE); end
  endtask

  task automatic test_mem_wait;
    drive(1, 1, 1, 0, 0); #1;
    n++; if (outs !== MEMR) begin f++; $display("FAIL mem_first: got %b want %b", outs, MEMR); end
    @(negedge clk); #1;
    n++; if (outs !== MEMW) begin f++; $display("FAIL mem_wait2: got %b want %b", outs, MEMW); end
    @(negedge clk); #1;
    n++; if (outs !== MEMW) begin f++; $display("FAIL mem_wait3: got %b want %b", outs, MEMW); end
    @(negedge clk); drive(0, 0, 1, 1, 0); #1;
    n++; if (outs !== MWOK) begin f++; $display("FAIL mem_ready: got %b want %b", outs, MWOK); end
    @(negedge clk); drive(0, 0, 0, 0, 0); #1;
    n++; if (outs !== IDLE) begin f++; $display("FAIL mem_back_run: got %b want %b", outs, IDLE); end
  endtask

  task automatic test_mem_timeout;
    drive(0, 0, 1, 0, 0);
    repeat (4) @(negedge clk);
    #1;
    n++; if (outs !== MEMW) begin f++; $display("FAIL timeout_early: got %b want %b", outs, MEMW); end
    @(negedge clk); #1;
    n++; if (outs !== (MEMW | 11'b1)) begin f++; $display("FAIL timeout_set: got %b want %b", outs, MEMW | 11'b1); end
    @(negedge clk); #1;
    n++; if (outs !== (MEMW | 11'b1)) begin f++; $display("FAIL timeout_sat: got %b want %b", outs, MEMW | 11'b1); end
    drive(0, 0, 1, 1, 0); #1;
    n++; if (outs !== (MWOK | 11'b1)) begin f++; $display("FAIL timeout_ready: got %b want %b", outs, MWOK | 11'b1); end
    @(negedge clk); drive(0, 0, 0, 0, 0); #1;
    n++; if (outs !== (IDLE | 11'b1)) begin f++; $display("FAIL mem_err_sticky: got %b want %b", outs, IDLE | 11'b1); end
    rst_n = 1'b0; #1;
    n++; if (outs !== IDLE) begin f++; $display("FAIL mem_err_reset: got %b want %b", outs, IDLE); end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_drain_halt;
    drive(0, 0, 0, 0, 1); #1;
    n++; if (outs !== LU) begin f++; $display("FAIL halt_detect: got %b want %b", outs, LU); end
    @(negedge clk); drive(0, 0, 0, 0, 0); #1;
    n++; if (outs !== DRN) begin f++; $display("FAIL drain1: got %b want %b", outs, DRN); end
    @(negedge clk); drive(0, 0, 1, 0, 0); #1;
    n++; if (outs !== DRNM) begin f++; $display("FAIL drain_memwait: got %b want %b", outs, DRNM); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); drive(0, 0, 0, 0, 0); #1;
      n++; if (outs !== DRN) begin f++; $display("FAIL drain_hold%0d: got %b want %b", i, outs, DRN); end
    end
    @(negedge clk); #1;
    n++; if (outs !== HLT) begin f++; $display("FAIL halted: got %b want %b", outs, HLT); end
    drive(1, 1, 0, 0, 1); #1;
    n++; if (outs !== HLT) begin f++; $display("FAIL halted_ignores: got %b want %b", outs, HLT); end
    @(negedge clk); #1;
    n++; if (outs !== HLT) begin f++; $display("FAIL halted_stays: got %b want %b", outs, HLT); end
    drive(0, 0, 0, 0, 0);
    rst_n = 1'b0; #1;
    n++; if (outs !== IDLE) begin f++; $display("FAIL halted_reset: got %b want %b", outs, IDLE); end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_async_reset_drain;
    drive(0, 0, 0, 0, 1);
    @(negedge clk); drive(0, 0, 0, 0, 0);
    @(negedge clk); #1;
    n++; if (outs !== DRN) begin f++; $display("FAIL drain_pre_reset: got %b want %b", outs, DRN); end
    #1 rst_n = 1'b0; #1;
    n++; if (outs !== IDLE) begin f++; $display("FAIL async_reset_drain: got %b want %b", outs, IDLE); end
    @(negedge clk); rst_n = 1'b1;
    repeat (5) @(negedge clk);
    #1;
    n++; if (outs !== IDLE) begin f++; $display("FAIL post_reset_run: got %b want %b", outs, IDLE); end
  endtask

`ifdef PIPE_PERF_CNT_EN
  task automatic test_perf_counters;
    rst_n = 1'b0; #1;
    n++; if ({cyc_cnt, stall_cnt, flush_cnt, memwait_cnt} !== 128'd0) begin f++; $display("FAIL perf_reset: got %0d/%0d/%0d/%0d want 0/0/0/0", cyc_cnt, stall_cnt, flush_cnt, memwait_cnt); end
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive(i == 2 || i == 5, i == 7, 0, 0, 0);
      @(negedge clk);
    end
    drive(0, 0, 0, 0, 0); #1;
    n++; if (cyc_cnt !== 32'd10) begin f++; $display("FAIL perf_cyc: got %0d want 10", cyc_cnt); end
    n++; if (stall_cnt !== 32'd2) begin f++; $display("FAIL perf_stall: got %0d want 2", stall_cnt); end
    n++; if (flush_cnt !== 32'd3) begin f++; $display("FAIL perf_flush: got %0d want 3", flush_cnt); end
    n++; if (memwait_cnt !== 32'd0) begin f++; $display("FAIL perf_memwait: got %0d want 0", memwait_cnt); end
  endtask
`endif

  initial begin
    test_reset;
    test_load_use;
    test_hz_and_redirect;
    test_mem_wait;
    test_mem_timeout;
    test_drain_halt;
    test_async_reset_drain;
`ifdef PIPE_PERF_CNT_EN
    test_perf_counters;
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n, f);
    $finish;
  end
endmodule
